// File: rtl/translator_in_ctrl.sv
// translator_in_ctrl: packet-level ingress sequencer for the NoC translator.
// Gates the upstream valid/ready handshake. For each packet it picks a
// destination round-robin among enabled ports that still hold credit, and it
// assigns a packet ID and a VC. For each beat it drives the header/payload
// mode select.
//
// Handshake contract (zero latency, no buffering):
//   A beat is accepted by the translator when o_tr_valid & i_tr_ready.
//   A beat is taken from upstream when i_valid & o_ready.
//   A beat taken from upstream while o_tr_valid is low is dropped
//   (this only happens to orphan non-sop beats seen in IDLE).
//   Upstream must hold i_valid and its sideband while o_tr_valid & !i_tr_ready.
module translator_in_ctrl #(
  parameter int NUM_VC    = 2,
  parameter int NOC_RADIX = 16,
  parameter int MAX_CRED  = 4,
  parameter int HDR_BEATS = 1,
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int DW  = $clog2(NOC_RADIX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic                 i_sop,
  input  logic                 i_eop,
  output logic                 o_ready,
  output logic                 o_tr_valid,
  input  logic                 i_tr_ready,
  output logic [DW-1:0]        o_dst,
  output logic [VCW-1:0]       o_vc,
  output logic                 o_payload,
  output logic [31:0]          o_pktid,
  input  logic [NOC_RADIX-1:0] i_dst_en,
  input  logic                 i_credit_valid,
  input  logic [DW-1:0]        i_credit_dst,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int CW = $clog2(MAX_CRED + 1);
  localparam int BW = (HDR_BEATS > 0) ? $clog2(HDR_BEATS + 1) : 1;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cred [NOC_RADIX];
  logic [DW-1:0]         rr_ptr;
  logic [DW-1:0]         dst_q;
  logic [31:0]           id_q;
  logic [31:0]           next_id;
  logic [BW-1:0]         beat_idx;
  logic [DW-1:0]         cand;
  logic                  cand_ok;
  logic                  acc;
  logic                  sop_acc;
  logic                  orphan;
  logic                  sop_in_pkt;
  logic                  cred_ovf;
  logic [NOC_RADIX-1:0]  cred_ret;
  logic [NOC_RADIX-1:0]  cred_use;
  int                    idx;

  // Round-robin search from rr_ptr for the first enabled destination with credit.
  always_comb begin
    cand    = rr_ptr;
    cand_ok = 1'b0;
    idx     = 0;
    for (int i = 0; i < NOC_RADIX; i++) begin
      idx = (int'(rr_ptr) + i) % NOC_RADIX;
      if (!cand_ok && i_dst_en[DW'(idx)] && (cred[DW'(idx)] != '0)) begin
        cand_ok = 1'b1;
        cand    = DW'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state: a sop without eop opens a packet, an accepted eop closes it.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sop_acc && !i_eop) state_n = PKT;
      PKT:     if (acc && i_eop)      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: handshake gating and orphan detection.
  always_comb begin
    o_tr_valid = 1'b0;
    o_ready    = 1'b0;
    orphan     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_sop) begin
            // Without a candidate the sop stalls; it is never dropped.
            o_tr_valid = cand_ok;
            o_ready    = cand_ok & i_tr_ready;
          end else begin
            o_ready = 1'b1;
            orphan  = 1'b1;
          end
        end
      end
      PKT: begin
        o_tr_valid = i_valid;
        o_ready    = i_tr_ready;
      end
      default: ;
    endcase
  end

  assign acc        = o_tr_valid & i_tr_ready;
  assign sop_acc    = (state == IDLE) & acc;
  assign sop_in_pkt = (state == PKT) & acc & i_sop;
  assign o_busy     = (state == PKT);
  assign o_dst      = (state == PKT) ? dst_q : cand;
  assign o_pktid    = (state == PKT) ? id_q : next_id;
  assign o_vc       = (NUM_VC > 1) ? o_pktid[VCW-1:0] : '0;
  assign o_payload  = (beat_idx >= BW'(HDR_BEATS));

  // Packet bookkeeping: latch route/ID on sop, advance pointer, ID and beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      dst_q    <= '0;
      id_q     <= '0;
      next_id  <= '0;
      beat_idx <= '0;
    end else if (sop_acc) begin
      dst_q    <= cand;
      id_q     <= next_id;
      next_id  <= next_id + 32'd1;
      rr_ptr   <= (cand == DW'(NOC_RADIX - 1)) ? '0 : cand + DW'(1);
      beat_idx <= (i_eop || HDR_BEATS == 0) ? '0 : BW'(1);
    end else if ((state == PKT) && acc) begin
      if (i_eop)                            beat_idx <= '0;
      else if (beat_idx < BW'(HDR_BEATS))   beat_idx <= beat_idx + BW'(1);
    end
  end

  // Per-destination credit return / consume decode and overflow detection.
  always_comb begin
    cred_ovf = 1'b0;
    for (int d = 0; d < NOC_RADIX; d++) begin
      cred_ret[d] = i_credit_valid && (i_credit_dst == DW'(d));
      cred_use[d] = sop_acc && (cand == DW'(d));
      if (cred_ret[d] && !cred_use[d] && (cred[d] == CW'(MAX_CRED))) cred_ovf = 1'b1;
    end
  end

  // Credit counters: simultaneous return and consume cancel; overflow saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NOC_RADIX; d++) cred[d] <= CW'(MAX_CRED);
    end else begin
      for (int d = 0; d < NOC_RADIX; d++) begin
        if (cred_ret[d] && !cred_use[d] && (cred[d] != CW'(MAX_CRED)))
          cred[d] <= cred[d] + CW'(1);
        else if (cred_use[d] && !cred_ret[d])
          cred[d] <= cred[d] - CW'(1);
      end
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_err <= 1'b0;
    else        o_err <= orphan | sop_in_pkt | cred_ovf;
  end

endmodule

// File: tb/tb_translator_in_ctrl.sv
// Bench for translator_in_ctrl: directed scenarios followed by a random
// traffic phase, all checked every cycle against a packet-level reference.
module tb_translator_in_ctrl;

  localparam int MAXC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic        o_ready, o_tr_valid;
  logic        i_tr_ready = 1'b1;
  logic [3:0]  o_dst;
  logic [0:0]  o_vc;
  logic        o_payload;
  logic [31:0] o_pktid;
  logic [15:0] i_dst_en = 16'h0001;
  logic        i_credit_valid = 1'b0;
  logic [3:0]  i_credit_dst = 4'd0;
  logic        o_busy, o_err;

  translator_in_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop), .o_ready(o_ready),
    .o_tr_valid(o_tr_valid), .i_tr_ready(i_tr_ready),
    .o_dst(o_dst), .o_vc(o_vc), .o_payload(o_payload), .o_pktid(o_pktid),
    .i_dst_en(i_dst_en), .i_credit_valid(i_credit_valid), .i_credit_dst(i_credit_dst),
    .o_busy(o_busy), .o_err(o_err)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: credits per port, rotation pointer, ID counter, packet context.
  int          m_cred [16];
  int          m_rr;
  logic [31:0] m_id;
  bit          m_busy;
  int          m_dst;
  logic [31:0] m_pid;
  int          m_beat;
  bit          m_err;

  // Values observed on the most recent step (for directed checks).
  logic        c_tv, c_rdy, c_pay, c_err, c_busy;
  logic [3:0]  c_dst;
  logic [31:0] c_pid;
  logic [0:0]  c_vc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 16; d++) m_cred[d] = MAXC;
    m_rr = 0; m_id = 32'd0; m_busy = 0; m_dst = 0; m_pid = 32'd0; m_beat = 0; m_err = 0;
  endfunction

  // One clock: check outputs mid-cycle against the reference, then advance it.
  task automatic step(output bit hs);
    int cand; bit cok; bit e_tv, e_rdy, e_pay, acc, err_n, used_ret;
    int e_dst; logic [31:0] e_pid; int cd;
    @(negedge clk);
    cok = 0; cand = 0;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = (m_rr + i) % 16;
      if (!cok && i_dst_en[d] && m_cred[d] > 0) begin cok = 1; cand = d; end
    end
    if (!m_busy) begin
      e_tv = i_valid && i_sop && cok;
      e_rdy = i_sop ? (cok && i_tr_ready) : 1'b1;
      e_dst = cand; e_pid = m_id; e_pay = 1'b0;
    end else begin
      e_tv = i_valid; e_rdy = i_tr_ready;
      e_dst = m_dst; e_pid = m_pid; e_pay = (m_beat >= 1);
    end
    chk("tr_valid", {31'd0, o_tr_valid}, {31'd0, e_tv});
    if (i_valid) chk("ready", {31'd0, o_ready}, {31'd0, e_rdy});
    if (m_busy || cok) chk("dst", {28'd0, o_dst}, e_dst);
    chk("pktid", o_pktid, e_pid);
    chk("vc", {31'd0, o_vc}, {31'd0, e_pid[0]});
    chk("payload", {31'd0, o_payload}, {31'd0, e_pay});
    chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
    chk("err", {31'd0, o_err}, {31'd0, m_err});
    c_tv = o_tr_valid; c_rdy = o_ready; c_pay = o_payload; c_err = o_err;
    c_busy = o_busy; c_dst = o_dst; c_pid = o_pktid; c_vc = o_vc;
    hs = i_valid && o_ready;
    // Advance the reference from the expected handshake.
    acc = e_tv && i_tr_ready;
    err_n = 0; used_ret = 0;
    if (!m_busy && i_valid && !i_sop) err_n = 1;
    if (m_busy && acc && i_sop) err_n = 1;
    if (i_credit_valid) begin
      cd = int'(i_credit_dst);
      if (!m_busy && acc && cand == cd) used_ret = 1;
      else if (m_cred[cd] == MAXC) err_n = 1;
      else m_cred[cd]++;
    end
    if (!m_busy && acc) begin
      if (!used_ret) m_cred[cand]--;
      m_dst = cand; m_pid = m_id; m_id = m_id + 32'd1; m_rr = (cand + 1) % 16;
      if (!i_eop) begin m_busy = 1; m_beat = 1; end else m_beat = 0;
    end else if (m_busy && acc) begin
      if (i_eop) begin m_busy = 0; m_beat = 0; end else m_beat = 1;
    end
    m_err = err_n;
    @(posedge clk); #1;
  endtask

  // Offer one beat and wait (bounded) until upstream sees it taken.
  task automatic beat(input bit s, input bit e);
    bit hs;
    hs = 0;
    i_valid = 1'b1; i_sop = s; i_eop = e;
    for (int k = 0; k < 40 && !hs; k++) step(hs);
    if (!hs) chk("beat_timeout", 32'd0, 32'd1);
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic reset_dut(input logic [15:0] en);
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_credit_valid = 1'b0; i_tr_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_dst_en = en;
  endtask

  initial begin : main
    bit hs;
    int exp_dst [3];
    bit pend, orph;
    int left, r;
    exp_dst = '{0, 2, 0};

    // Reset values.
    reset_dut(16'h0005);
    step(hs);
    chk("rst_pktid", c_pid, 32'd0);
    chk("rst_dst", {28'd0, c_dst}, 32'd0);
    chk("rst_payload", {31'd0, c_pay}, 32'd0);
    chk("rst_err", {31'd0, c_err}, 32'd0);
    chk("rst_busy", {31'd0, c_busy}, 32'd0);

    // Destination rotation over ports 0 and 2.
    for (int p = 0; p < 3; p++) begin
      beat(1'b1, 1'b0);
      chk("rot_dst", {28'd0, c_dst}, exp_dst[p]);
      chk("rot_pktid", c_pid, p);
      chk("rot_vc", {31'd0, c_vc}, p % 2);
      chk("rot_pay_hdr", {31'd0, c_pay}, 32'd0);
      beat(1'b0, 1'b1);
      chk("rot_pay_data", {31'd0, c_pay}, 32'd1);
      chk("rot_dst_hold", {28'd0, c_dst}, exp_dst[p]);
    end

    // Credit exhaustion on port 1 and release by a credit return.
    reset_dut(16'h0002);
    for (int p = 0; p < 4; p++) begin
      beat(1'b1, 1'b1);
      chk("cred_dst", {28'd0, c_dst}, 32'd1);
    end
    i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(hs);
      chk("cred_stall_rdy", {31'd0, c_rdy}, 32'd0);
      chk("cred_stall_tv", {31'd0, c_tv}, 32'd0);
    end
    i_credit_valid = 1'b1; i_credit_dst = 4'd1;
    step(hs);
    chk("cred_land_cycle", {31'd0, hs}, 32'd0);
    i_credit_valid = 1'b0;
    step(hs);
    chk("cred_accept_next", {31'd0, hs}, 32'd1);
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;

    // Backpressure: 3-beat packet, beat 2 stalled 4 cycles.
    reset_dut(16'h0008);
    beat(1'b1, 1'b0);
    i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_tr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(hs);
      chk("bp_ready", {31'd0, c_rdy}, 32'd0);
      chk("bp_dst", {28'd0, c_dst}, 32'd3);
      chk("bp_pay", {31'd0, c_pay}, 32'd1);
      chk("bp_pktid", c_pid, 32'd0);
    end
    i_tr_ready = 1'b1;
    step(hs);
    chk("bp_release", {31'd0, hs}, 32'd1);
    beat(1'b0, 1'b1);
    step(hs);
    chk("bp_done_busy", {31'd0, c_busy}, 32'd0);

    // Orphan beat in IDLE.
    i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b1;
    step(hs);
    chk("orph_dropped", {31'd0, hs & ~c_tv}, 32'd1);
    i_valid = 1'b0;
    step(hs);
    chk("orph_err", {31'd0, c_err}, 32'd1);
    step(hs);
    chk("orph_err_clear", {31'd0, c_err}, 32'd0);

    // Sop in the middle of a packet.
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk("midsop_pass", {31'd0, c_tv}, 32'd1);
    step(hs);
    chk("midsop_err", {31'd0, c_err}, 32'd1);
    beat(1'b0, 1'b1);

    // Credit return to a full counter.
    i_credit_valid = 1'b1; i_credit_dst = 4'd5;
    step(hs);
    i_credit_valid = 1'b0;
    step(hs);
    chk("ovf_err", {31'd0, c_err}, 32'd1);
    step(hs);
    chk("ovf_err_clear", {31'd0, c_err}, 32'd0);
    // Port 5 still holds exactly 4 credits.
    i_dst_en = 16'h0020;
    for (int p = 0; p < 4; p++) beat(1'b1, 1'b1);
    i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1;
    step(hs);
    chk("ovf_sat_stall", {31'd0, c_rdy}, 32'd0);
    i_valid = 1'b0;

    // Single-beat packet keeps IDLE and header mode.
    i_dst_en = 16'h0001;
    beat(1'b1, 1'b1);
    step(hs);
    chk("single_busy", {31'd0, c_busy}, 32'd0);
    chk("single_pay", {31'd0, c_pay}, 32'd0);

    // Reset mid-packet restores credits and IDLE; later non-sop is an orphan.
    for (int p = 0; p < 2; p++) beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    reset_dut(16'h0001);
    i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b1;
    step(hs);
    chk("rstmid_busy", {31'd0, c_busy}, 32'd0);
    i_valid = 1'b0;
    step(hs);
    chk("rstmid_orph_err", {31'd0, c_err}, 32'd1);
    for (int p = 0; p < 4; p++) beat(1'b1, 1'b1);
    i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1;
    step(hs);
    chk("rstmid_cred4", {31'd0, c_rdy}, 32'd0);
    i_valid = 1'b0;

    // Random traffic against the reference.
    reset_dut(16'h00F1);
    pend = 0; orph = 0; left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend) begin
        if (left == 0) begin
          if ($urandom_range(0, 9) == 0)
            i_dst_en = 16'($urandom) | (16'd1 << $urandom_range(0, 15));
          r = $urandom_range(0, 19);
          if (r < 12) begin
            left = $urandom_range(1, 4);
            i_valid = 1'b1; i_sop = 1'b1; i_eop = (left == 1); pend = 1;
          end else if (r == 12) begin
            i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'($urandom_range(0, 1));
            pend = 1; orph = 1;
          end else begin
            i_valid = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          i_valid = 1'b0;
        end else begin
          i_valid = 1'b1; i_sop = ($urandom_range(0, 29) == 0); i_eop = (left == 1); pend = 1;
        end
      end
      i_tr_ready = ($urandom_range(0, 3) != 0);
      i_credit_valid = ($urandom_range(0, 3) == 0);
      i_credit_dst = 4'($urandom_range(0, 15));
      step(hs);
      if (pend && hs) begin
        pend = 0;
        if (!orph) left--;
        orph = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/translator_in_ctrl.md
# translator_in_ctrl

Packet-level sequencer for the NoC ingress translator. It gates the Avalon-ST valid/ready handshake between the upstream source and the translator. Per packet it selects a destination router port by round-robin among enabled ports that hold credit, then assigns a packet ID and VC. Per beat it drives the translator's header/payload mode select.

## Interface
- `NUM_VC`, 2: virtual channels; VC field width is `max(1,$clog2(NUM_VC))`.
- `NOC_RADIX`, 16: destination ports; destination field width is `$clog2(NOC_RADIX)`.
- `MAX_CRED`, 4: outstanding-packet credits per destination.
- `HDR_BEATS`, 1: leading beats of each packet sent in header mode.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_valid` in 1: upstream Avalon-ST valid.
- `i_sop` in 1: upstream start of packet.
- `i_eop` in 1: upstream end of packet.
- `o_ready` out 1: ready to upstream.
- `o_tr_valid` out 1: gated valid to the translator sink.
- `i_tr_ready` in 1: NoC ready, the translator's `o_ready_in`.
- `o_dst` out $clog2(NOC_RADIX): destination, to the translator's `i_dst_in`.
- `o_vc` out VC width: VC, to the translator's `i_vc_in`.
- `o_payload` out 1: 1 selects payload mode, 0 selects header mode, to `i_payload_in`.
- `o_pktid` out 32: packet ID, to `i_pktid_in`.
- `i_dst_en` in NOC_RADIX: per-destination enable mask.
- `i_credit_valid` in 1: one credit returned this cycle.
- `i_credit_dst` in $clog2(NOC_RADIX): destination of the returned credit.
- `o_busy` out 1: a packet is in progress (state PKT).
- `o_err` out 1: one-cycle error pulse, registered.

## Operation
- State machine, two states:
  - IDLE: no packet in progress.
  - PKT: a packet has started and its eop beat has not yet been accepted.
- Definitions:
  - A beat is accepted when `o_tr_valid & i_tr_ready`.
  - A dropped beat is `i_valid & o_ready & !o_tr_valid`.
- Candidate selection:
  - Combinational search of destinations `rr_ptr, rr_ptr+1, ...` modulo NOC_RADIX.
  - The candidate is the first destination with `i_dst_en[d]==1` and `cred[d]>0`.
  - `cand_ok`=0 if no destination qualifies.
- IDLE behaviour:
  - `o_dst` = candidate.
  - `i_valid & i_sop`:
    - If `cand_ok`: `o_tr_valid=1` and `o_ready=i_tr_ready`.
    - If not `cand_ok`: `o_tr_valid=0` and `o_ready=0` (stall, nothing is dropped).
  - `i_valid & !i_sop`: orphan beat. Drop it (`o_ready=1`, `o_tr_valid=0`) and pulse `o_err` next cycle.
- Accepted sop beat in IDLE:
  - Latch the candidate into `dst_q`.
  - Latch `o_pktid` into `id_q`.
  - Decrement `cred[cand]`.
  - `rr_ptr <= cand+1` (mod NOC_RADIX).
  - Increment `next_id`.
  - Set `beat_idx` to 1.
  - If `i_eop` is also set, stay in IDLE (single-beat packet). Otherwise go to PKT.
- PKT behaviour:
  - `o_tr_valid=i_valid`, `o_ready=i_tr_ready`.
  - `o_dst=dst_q`, `o_pktid=id_q`.
  - Each accepted beat increments `beat_idx`, saturating at HDR_BEATS.
  - An accepted beat with `i_eop` returns to IDLE.
  - `i_sop` seen on an accepted beat in PKT: pass the beat through as a continuation beat and pulse `o_err`.
- Per-beat outputs:
  - `o_payload = (beat_idx >= HDR_BEATS)`, where `beat_idx` is 0 on the sop beat. With HDR_BEATS=0, every beat is payload mode.
  - `o_vc = pktid[VC-1:0]`, i.e. VCs alternate per packet. With NUM_VC=1, `o_vc` is 0.
  - In IDLE, `o_pktid = next_id`.
  - `next_id` wraps 0xFFFFFFFF to 0.
- Credits:
  - `cred[d]` is a counter of width $clog2(MAX_CRED+1).
  - Return and consume of the same destination in the same cycle: net unchanged.
  - A return to a counter already at MAX_CRED: the counter stays at MAX_CRED and `o_err` pulses.
  - Returns are accepted in any state.
- `i_dst_en` changes take effect in the next candidate search. They never affect a packet already in progress.

## Timing
- Handshake path:
  - Valid/ready gating is combinational with zero latency; there is no buffering.
  - `i_valid` must hold while `o_tr_valid & !i_tr_ready`.
  - `o_dst`, `o_vc`, `o_pktid` and `o_payload` are stable for every beat of a packet.
- State, counters, `rr_ptr` and `o_err` update on the rising edge of `clk`.
- Reset values (`rst_n` low):
  - State IDLE, `rr_ptr=0`, `next_id=0`, `beat_idx=0`.
  - `cred[*]=MAX_CRED`, `o_err=0`, `o_busy=0`.
  - `o_pktid=0`, `o_vc=0`, `o_payload=0` (HDR_BEATS≥1).
  - `o_dst` = first enabled port from 0.
- Reset asserted mid-packet:
  - The packet is abandoned and all credits are restored.
  - After release, upstream non-sop beats are dropped as orphans with `o_err`.
- Throughput: one beat per cycle. Back-to-back packets are allowed: the sop of packet N+1 can be accepted the cycle after the eop of packet N.

## Test plan
- Destination rotation:
  - Stimulus: `i_dst_en=16'h0005`; three 2-beat packets; `i_tr_ready=1`.
  - Response: `o_dst` is 0, 2, 0; `o_pktid` is 0, 1, 2; `o_vc` is 0, 1, 0.
  - Response: `o_payload` is 0 then 1 within each packet.
- Credit exhaustion:
  - Stimulus: `i_dst_en=16'h0002`, MAX_CRED=4; send 5 packets.
  - Response: the 5th sop stalls with `o_ready=0` and `o_tr_valid=0`.
  - Stimulus: `i_credit_valid=1`, `i_credit_dst=1`.
  - Response: the 5th sop is accepted the same cycle the credit lands plus 1.
- Backpressure:
  - Stimulus: 3-beat packet with `i_tr_ready` low for 4 cycles on beat 2.
  - Response: `o_dst`, `o_pktid` and `o_payload=1` are held; `o_ready=0` during the stall; no beat is lost.
- Protocol errors:
  - Stimulus: a non-sop beat in IDLE.
  - Response: the beat is dropped and `o_err` pulses for 1 cycle.
  - Stimulus: sop mid-packet.
  - Response: the beat is passed through and `o_err` pulses.
  - Stimulus: a credit return to a full counter.
  - Response: the counter stays at 4 and `o_err` pulses.
- Edge cases:
  - Single-beat packet (sop+eop): state stays IDLE and `beat_idx` returns to 0.
  - `next_id` preset to 0xFFFFFFFF: wraps to 0.
  - Reset mid-packet: `cred` returns to 4 and state is IDLE.
